// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage 16-bit CPU: opcode constants, default
// field widths and the hazard-unit state encoding.
package cpu_pkg;

    localparam int unsigned INSTR_W_DEF = 16;
    localparam int unsigned OPC_W_DEF   = 4;
    localparam int unsigned RADDR_W_DEF = 4;
    localparam int unsigned CNT_W_DEF   = 16;

    // Wide enough for the 1..7 load-use depth and HLT drain length
    localparam int unsigned CYC_W = 3;

    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_LHB = 4'hA;
    localparam logic [3:0] OP_LLB = 4'hB;
    localparam logic [3:0] OP_RET = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] OP_ALU_LIMIT = 4'h8;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_DRAIN  = 2'd1,
        HZ_HALTED = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic bubble_id_ex;
        logic freeze;
    } hz_ctrl_t;

endpackage

// File: rtl/hazard_unit_pl_src_decode.sv
// Opcode to source-register usage decode; shared with the forwarding unit.
module src_decode
    import cpu_pkg::*;
#(
    parameter int unsigned OPC_W = OPC_W_DEF
) (
    input  logic [OPC_W-1:0] opc,
    output logic             src_a_used,
    output logic             src_b_used,
    output logic             src_c_used
);

    always_comb begin
        src_a_used = 1'b0;
        src_b_used = 1'b0;
        src_c_used = 1'b0;
        if (opc < OPC_W'(OP_ALU_LIMIT)) begin
            src_b_used = 1'b1;
            src_c_used = 1'b1;
        end else if (opc == OPC_W'(OP_LW)) begin
            src_b_used = 1'b1;
        end else if (opc == OPC_W'(OP_SW)) begin
            // store reads the base in B and the data register in A
            src_b_used = 1'b1;
            src_a_used = 1'b1;
        end else if ((opc == OPC_W'(OP_LHB)) || (opc == OPC_W'(OP_LLB))) begin
            src_a_used = 1'b1;
        end else if (opc == OPC_W'(OP_RET)) begin
            src_b_used = 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit_pl.sv
// Load-use / HLT / memory-busy hazard detection and pipeline control for the
// 5-stage CPU; drives PC hold, IF/ID hold, ID/EX bubble and global freeze.
module hazard_unit_pl
    import cpu_pkg::*;
#(
    parameter int unsigned INSTR_W      = INSTR_W_DEF,
    parameter int unsigned OPC_W        = OPC_W_DEF,
    parameter int unsigned RADDR_W      = RADDR_W_DEF,
    parameter int unsigned LOAD_USE_CYC = 1,
    parameter int unsigned HLT_DRAIN    = 3,
    parameter bit          ZERO_REG_EN  = 1'b1,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] if_id_instr,
    input  logic               if_id_valid,
    input  logic [INSTR_W-1:0] id_ex_instr,
    input  logic               id_ex_valid,
    input  logic               id_ex_mem_to_reg,
    input  logic               flush,
    input  logic               mem_busy,
    output logic               stall_pc,
    output logic               stall_if_id,
    output logic               bubble_id_ex,
    output logic               freeze,
    output logic               hlt_out,
    output logic [CNT_W-1:0]   lu_stall_cnt
);

    hz_state_e          state_q, state_nx;
    logic [CYC_W-1:0]   lu_cnt_q, lu_cnt_nx;
    logic [CYC_W-1:0]   drain_cnt_q, drain_cnt_nx;
    logic [OPC_W-1:0]   opc;
    logic [RADDR_W-1:0] fld_a, fld_b, fld_c, ld_dest;
    logic               src_a_used, src_b_used, src_c_used;
    logic               src_match, zero_exempt;
    logic               hz_now, lu_stall, hlt_accept;
    hz_ctrl_t           ctrl;
    logic               unused_instr_bits;

    assign opc     = if_id_instr[INSTR_W-1 -: OPC_W];
    assign fld_a   = if_id_instr[3*RADDR_W-1 -: RADDR_W];
    assign fld_b   = if_id_instr[2*RADDR_W-1 -: RADDR_W];
    assign fld_c   = if_id_instr[RADDR_W-1:0];
    assign ld_dest = id_ex_instr[3*RADDR_W-1 -: RADDR_W];

    // Only a few fields of each instruction matter here
    assign unused_instr_bits = ^{if_id_instr, id_ex_instr};

    src_decode #(
        .OPC_W (OPC_W)
    ) u_src_decode (
        .opc        (opc),
        .src_a_used (src_a_used),
        .src_b_used (src_b_used),
        .src_c_used (src_c_used)
    );

    // Load-use detection against the load destination in ID/EX
    assign src_match = (src_a_used && (fld_a == ld_dest)) ||
                       (src_b_used && (fld_b == ld_dest)) ||
                       (src_c_used && (fld_c == ld_dest));
    assign zero_exempt = ZERO_REG_EN && (ld_dest == '0);
    assign hz_now      = if_id_valid && id_ex_valid && id_ex_mem_to_reg &&
                         src_match && !zero_exempt;
    assign lu_stall    = hz_now || (lu_cnt_q != '0);
    assign hlt_accept  = if_id_valid && (opc == OPC_W'(OP_HLT)) &&
                         !lu_stall && !flush && !mem_busy;

    // State register and stall/drain counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HZ_RUN;
            lu_cnt_q    <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_nx;
            lu_cnt_q    <= lu_cnt_nx;
            drain_cnt_q <= drain_cnt_nx;
        end
    end

    // Next state; a memory stall holds everything
    always_comb begin
        state_nx     = state_q;
        drain_cnt_nx = drain_cnt_q;
        if (!mem_busy) begin
            unique case (state_q)
                HZ_RUN: begin
                    if (hlt_accept) begin
                        state_nx     = HZ_DRAIN;
                        drain_cnt_nx = CYC_W'(HLT_DRAIN - 1);
                    end
                end
                HZ_DRAIN: begin
                    // A redirect means the HLT was on the wrong path
                    if (flush) begin
                        state_nx     = HZ_RUN;
                        drain_cnt_nx = '0;
                    end else if (drain_cnt_q == '0) begin
                        state_nx = HZ_HALTED;
                    end else begin
                        drain_cnt_nx = drain_cnt_q - CYC_W'(1);
                    end
                end
                HZ_HALTED: begin
                    state_nx = HZ_HALTED;
                end
                default: begin
                    state_nx     = HZ_RUN;
                    drain_cnt_nx = '0;
                end
            endcase
        end
    end

    // Load-use stall length; a new hazard reloads the full depth
    always_comb begin
        lu_cnt_nx = lu_cnt_q;
        if (!mem_busy) begin
            if (flush) begin
                lu_cnt_nx = '0;
            end else if (hz_now) begin
                lu_cnt_nx = CYC_W'(LOAD_USE_CYC - 1);
            end else if (lu_cnt_q != '0) begin
                lu_cnt_nx = lu_cnt_q - CYC_W'(1);
            end
        end
    end

    // Control outputs, forced low while reset is asserted
    always_comb begin
        ctrl = '0;
        if (rst) begin
            if (mem_busy) begin
                ctrl.freeze      = 1'b1;
                ctrl.stall_pc    = 1'b1;
                ctrl.stall_if_id = 1'b1;
            end else begin
                if (lu_stall && !flush) begin
                    ctrl.stall_pc     = 1'b1;
                    ctrl.stall_if_id  = 1'b1;
                    ctrl.bubble_id_ex = 1'b1;
                end
                if (state_q != HZ_RUN) begin
                    ctrl.stall_pc    = 1'b1;
                    ctrl.stall_if_id = 1'b1;
                end
            end
        end
    end

    assign stall_pc     = ctrl.stall_pc;
    assign stall_if_id  = ctrl.stall_if_id;
    assign bubble_id_ex = ctrl.bubble_id_ex;
    assign freeze       = ctrl.freeze;

    // Sticky halt flag, rising HLT_DRAIN clocks after the accepting edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hlt_out <= 1'b0;
        end else begin
            hlt_out <= (state_nx == HZ_HALTED);
        end
    end

    // Saturating load-use stall cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lu_stall_cnt <= '0;
        end else if (lu_stall && !mem_busy && (lu_stall_cnt != '1)) begin
            lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_unit_pl.md
Name: hazard_unit_pl

Overview:
- Parametrised hazard-detection and pipeline-control unit for the 5-stage 16-bit CPU; successor to the single-cycle load-use/HLT detector.
- Sits beside the IF/ID and ID/EX pipeline registers and drives PC hold, IF/ID hold, ID/EX bubble insertion and global freeze.
- New over the previous generation:
  - configurable register-field width and load-use stall depth;
  - valid-qualified detection and zero-register exemption;
  - abortable HLT drain;
  - memory-busy freeze;
  - saturating stall performance counter.

Parameters:
- INSTR_W, 16, instruction width; must satisfy INSTR_W >= OPC_W + 3*RADDR_W.
- OPC_W, 4, opcode field width; opcode = instr[INSTR_W-1 -: OPC_W].
- RADDR_W, 4, register-address width. Field A = instr[3*RADDR_W-1 -: RADDR_W], B = instr[2*RADDR_W-1 -: RADDR_W], C = instr[RADDR_W-1:0].
- LOAD_USE_CYC, 1, stall cycles per load-use hazard; legal range 1..7.
- HLT_DRAIN, 3, cycles from HLT acceptance to hlt_out; legal range 1..7.
- ZERO_REG_EN, 1, when 1, register 0 never raises a hazard.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_id_instr  in  INSTR_W  instruction in IF/ID.
- if_id_valid  in  1  IF/ID holds a real instruction.
- id_ex_instr  in  INSTR_W  instruction in ID/EX.
- id_ex_valid  in  1  ID/EX holds a real instruction.
- id_ex_mem_to_reg  in  1  ID/EX instruction is a load.
- flush  in  1  taken-branch redirect; squashes IF/ID.
- mem_busy  in  1  data memory not ready.
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold IF/ID register.
- bubble_id_ex  out  1  load NOP into ID/EX.
- freeze  out  1  hold every pipeline register.
- hlt_out  out  1  processor halted; sticky.
- lu_stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, lu_cnt=0, drain_cnt=0, hlt_out=0, lu_stall_cnt=0. All outputs are 0 during reset.
- Source decode on IF/ID opcode:
  - 0000-0111 (ALU): srcs B, C.
  - 1000 (LW): src B.
  - 1001 (SW): srcs B, A.
  - 1010/1011 (LHB/LLB): src A.
  - 1110: src B.
  - All other opcodes: no sources.
- Load destination = field A of id_ex_instr.
- hz_now = if_id_valid & id_ex_valid & id_ex_mem_to_reg & (a used src == dest) & !(ZERO_REG_EN & dest == 0).
- Stall logic:
  - lu_stall = hz_now | (lu_cnt != 0).
  - When lu_stall: stall_pc=1, stall_if_id=1, bubble_id_ex=1. All are combinational, asserted in the same cycle as hz_now.
  - On a hz_now edge, lu_cnt <= LOAD_USE_CYC-1; otherwise lu_cnt decrements while nonzero.
  - With LOAD_USE_CYC=1, exactly one stall cycle, because the bubble clears ID/EX.
- States: RUN, DRAIN, HALTED.
  - RUN -> DRAIN when if_id_valid & opcode==1111 & !lu_stall & !flush & !mem_busy. drain_cnt <= HLT_DRAIN-1.
  - DRAIN: stall_pc=1 and stall_if_id=1 (no new fetches; older instructions retire). Decrement drain_cnt; at 0 -> HALTED.
  - DRAIN + flush: abort, return to RUN (HLT was wrong-path), drain_cnt=0.
  - HALTED: hlt_out=1, stall_pc=1, stall_if_id=1. Exit only by reset.
- Priority, high to low: rst > mem_busy > flush > load-use > HLT.
- mem_busy=1:
  - freeze=stall_pc=stall_if_id=1, bubble_id_ex=0.
  - lu_cnt, drain_cnt, state and counter all hold.
  - hz_now is not re-armed.
- flush=1 (without mem_busy):
  - bubble_id_ex=0 and stall outputs are 0 from load-use (IF/ID is squashed).
  - lu_cnt is cleared.
- lu_stall_cnt increments each cycle lu_stall=1 and mem_busy=0. It saturates at all-ones.
- Stall outputs are purely combinational from state plus inputs; no output depends on a previous-cycle detection except through lu_cnt/drain_cnt.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants: OP_LW, OP_SW, OP_LHB, OP_LLB, OP_RET, OP_HLT;
  - state enum HZ_RUN/HZ_DRAIN/HZ_HALTED;
  - default widths.
- One sub-module src_decode (opcode -> src_a_used/src_b_used/src_c_used). It is reused by the forwarding unit.

Test Plan:
- LW r3,[r2] in ID/EX (id_ex_instr=16'h8320, mem_to_reg=1) with ADD r5,r3,r4 in IF/ID (16'h0534), LOAD_USE_CYC=1 -> stall_pc=stall_if_id=bubble_id_ex=1 for exactly 1 cycle; lu_stall_cnt=1.
- Same pair with LOAD_USE_CYC=3 -> stall and bubble high for 3 consecutive cycles, then 0; counter=3.
- LW r0 destination followed by a consumer of r0, ZERO_REG_EN=1 -> no stall. The same stimulus with id_ex_valid=0 -> no stall.
- HLT (16'hF000) valid in IF/ID, HLT_DRAIN=3 -> stall_pc high from the next cycle; hlt_out=1 exactly 3 cycles after acceptance; still 1 after 10 more cycles.
- HLT accepted, then flush in the 2nd drain cycle -> hlt_out never asserts; state returns to RUN; stall_pc=0 the next cycle.
- Load-use hazard with mem_busy=1 for 4 cycles -> freeze=1 and bubble=0 for 4 cycles, counter frozen; then 1 stall cycle. rst pulled low mid-stall -> all outputs 0 immediately, without waiting for clk.
